// File: rtl/secuencia_leer_if.sv
// Bus bundle between the RTC read-sequence controller and its surroundings:
// start/done handshake, bus-cycle request/completion and local-bank write port.
interface secuencia_leer_if;
  logic       Inicio_L;
  logic       Fin_ciclo;
  logic [7:0] dato_in;
  logic       Rd_req;
  logic [7:0] dir_R;
  logic [3:0] sel_reg_R;
  logic       Wr_local;
  logic [7:0] dato_R;
  logic       ocupado;
  logic       Fin_L;
  logic       err_L;

  modport master (
    input  Inicio_L, Fin_ciclo, dato_in,
    output Rd_req, dir_R, sel_reg_R, Wr_local, dato_R, ocupado, Fin_L, err_L
  );

  modport slave (
    output Inicio_L, Fin_ciclo, dato_in,
    input  Rd_req, dir_R, sel_reg_R, Wr_local, dato_R, ocupado, Fin_L, err_L
  );
endinterface

// File: rtl/secuencia_leer.sv
// Reads the nine RTC time/date/timer registers into the local bank: 3 cycles per register
// when Fin_ciclo comes in the first WAIT cycle; stalls in WAIT until Fin_ciclo or TIMEOUT.
module secuencia_leer #(
  parameter int N_REG   = 9,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  secuencia_leer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [7:0] wait_cnt;
  logic [7:0] dato_q;
  logic       err_q;
  logic [7:0] dir_tab;
  logic [7:0] max_tab;
  logic       ultimo;
  logic       vencido;
  logic       fuera_rango;

  assign ultimo  = (idx == 4'(N_REG - 1));
  assign vencido = (wait_cnt == 8'(TIMEOUT));

  // Valid BCD bytes order the same as their binary values, so a plain compare suffices.
  assign fuera_rango = (dato_q[7:4] > 4'd9) || (dato_q[3:0] > 4'd9) || (dato_q > max_tab);

  always_comb begin
    dir_tab = 8'h21;
    max_tab = 8'h59;
    case (idx)
      4'd0:    begin dir_tab = 8'h21; max_tab = 8'h59; end
      4'd1:    begin dir_tab = 8'h22; max_tab = 8'h59; end
      4'd2:    begin dir_tab = 8'h23; max_tab = 8'h23; end
      4'd3:    begin dir_tab = 8'h24; max_tab = 8'h31; end
      4'd4:    begin dir_tab = 8'h25; max_tab = 8'h12; end
      4'd5:    begin dir_tab = 8'h26; max_tab = 8'h99; end
      4'd6:    begin dir_tab = 8'h41; max_tab = 8'h59; end
      4'd7:    begin dir_tab = 8'h42; max_tab = 8'h59; end
      4'd8:    begin dir_tab = 8'h43; max_tab = 8'h23; end
      default: begin dir_tab = 8'h21; max_tab = 8'h59; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.Inicio_L) state_nxt = REQ;
      REQ:  state_nxt = WAIT;
      // Fin_ciclo is checked first so a completion on the timeout cycle still loads.
      WAIT: begin
        if (bus.Fin_ciclo) begin
          state_nxt = LOAD;
        end else if (vencido) begin
          state_nxt = DONE;
        end
      end
      LOAD:    state_nxt = ultimo ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 4'd0;
      wait_cnt <= 8'd0;
      dato_q   <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Inicio_L) begin
            idx   <= 4'd0;
            err_q <= 1'b0;
          end
        end
        REQ: wait_cnt <= 8'd0;
        WAIT: begin
          if (bus.Fin_ciclo) begin
            dato_q <= bus.dato_in;
          end else if (vencido) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        LOAD: begin
          if (fuera_rango) err_q <= 1'b1;
          if (!ultimo) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Rd_req   = (state == REQ);
    bus.Wr_local = (state == LOAD);
    bus.Fin_L    = (state == DONE);
    bus.ocupado  = (state != IDLE);
  end

  assign bus.dir_R     = dir_tab;
  assign bus.sel_reg_R = idx;
  assign bus.dato_R    = dato_q;
  assign bus.err_L     = err_q;

endmodule

// File: tb/tb_secuencia_leer.sv
// Directed and randomized bench for secuencia_leer with a cycle-count and range model.
module tb_secuencia_leer;

  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] dat      [9];
  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  int         lim_dec  [9] = '{59, 59, 23, 31, 12, 99, 59, 59, 23};
  logic [7:0] nominal  [9] = '{8'h45, 8'h30, 8'h17, 8'h28, 8'h11, 8'h16, 8'h10, 8'h05, 8'h01};

  secuencia_leer_if bus ();

  secuencia_leer #(.N_REG(9), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A byte is acceptable when both digits are decimal and its decimal value is within the limit.
  function automatic bit bcd_ok(input int k, input logic [7:0] v);
    int hi = int'(v[7:4]);
    int lo = int'(v[3:0]);
    return (hi <= 9) && (lo <= 9) && ((hi * 10 + lo) <= lim_dec[k]);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk(tag, {bus.Rd_req, bus.Wr_local, bus.Fin_L, bus.ocupado, bus.err_L,
              bus.dato_R, bus.dir_R, bus.sel_reg_R},
             {5'b0, 8'h00, 8'h21, 4'h0});
  endtask

  // hold_idx: register whose Fin_ciclo is withheld (-1 none); late_idx/late_n: extra WAIT cycles.
  task automatic run_seq(input string tag, input int hold_idx, input int late_idx,
                         input int late_n, input bit noise);
    logic [7:0] rd_q[$];
    logic [7:0] wr_d[$];
    logic [3:0] wr_s[$];
    int         wr_c[$];
    int         c, pend, fin_c, err_c, nk, cyc, bad, fin_e, err_rise_e, nreq_e, nld_e, d;
    int         ld_e[9];
    logic [7:0] cur;
    bit         err_e;
    pend  = -1;
    fin_c = -1;
    err_c = -1;
    cur   = 8'h00;
    @(negedge clk);
    bus.Inicio_L = 1'b1;
    @(posedge clk);
    c = 1;
    while (fin_c < 0 && c < 400) begin
      @(negedge clk);
      bus.Inicio_L  = 1'b0;
      bus.Fin_ciclo = 1'b0;
      bus.dato_in   = 8'($urandom);
      if (c == 1) begin
        chk({tag, " err_clear"}, 32'(bus.err_L), 32'd0);
        chk({tag, " busy"}, 32'(bus.ocupado), 32'd1);
      end
      if (bus.Rd_req) begin
        nk = rd_q.size();
        rd_q.push_back(bus.dir_R);
        cur  = dat[nk % 9];
        pend = (nk == hold_idx) ? -1 : c + 1 + ((nk == late_idx) ? late_n : 0);
      end
      if (c == pend) begin
        bus.Fin_ciclo = 1'b1;
        bus.dato_in   = cur;
      end
      if (noise && (bus.Rd_req || bus.Wr_local)) begin
        bus.Inicio_L  = 1'b1;
        bus.Fin_ciclo = 1'b1;
      end
      if (bus.Wr_local) begin
        wr_d.push_back(bus.dato_R);
        wr_s.push_back(bus.sel_reg_R);
        wr_c.push_back(c);
      end
      if (bus.err_L && err_c < 0) err_c = c;
      if (bus.Fin_L) fin_c = c;
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    bus.Inicio_L  = 1'b0;
    bus.Fin_ciclo = 1'b0;
    chk({tag, " idle_after"}, 32'(bus.ocupado), 32'd0);

    cyc    = 1;
    bad    = -1;
    fin_e  = -1;
    nreq_e = (hold_idx >= 0) ? hold_idx + 1 : 9;
    nld_e  = (hold_idx >= 0) ? hold_idx : 9;
    for (int k = 0; k < 9; k++) ld_e[k] = -1;
    for (int k = 0; k < nreq_e; k++) begin
      if (k == hold_idx) begin
        fin_e = cyc + TO + 2;
      end else begin
        d       = (k == late_idx) ? late_n : 0;
        ld_e[k] = cyc + 2 + d;
        if (!bcd_ok(k, dat[k]) && bad < 0) bad = k;
        cyc += 3 + d;
      end
    end
    if (hold_idx < 0) fin_e = cyc;
    err_e      = (bad >= 0) || (hold_idx >= 0);
    err_rise_e = (bad >= 0) ? ld_e[bad] + 1 : ((hold_idx >= 0) ? fin_e : -1);

    chk({tag, " rd_count"}, 32'(rd_q.size()), 32'(nreq_e));
    for (int k = 0; k < rd_q.size() && k < nreq_e; k++)
      chk($sformatf("%s rd_addr[%0d]", tag, k), 32'(rd_q[k]), 32'(addr_tab[k]));
    chk({tag, " wr_count"}, 32'(wr_d.size()), 32'(nld_e));
    for (int k = 0; k < wr_d.size() && k < nld_e; k++) begin
      chk($sformatf("%s wr_sel[%0d]", tag, k), 32'(wr_s[k]), 32'(k));
      chk($sformatf("%s wr_dat[%0d]", tag, k), 32'(wr_d[k]), 32'(dat[k]));
      chk($sformatf("%s wr_cyc[%0d]", tag, k), 32'(wr_c[k]), 32'(ld_e[k]));
    end
    chk({tag, " fin_cycle"}, 32'(fin_c), 32'(fin_e));
    chk({tag, " err_rise"}, 32'(err_c), 32'(err_rise_e));
    chk({tag, " err_final"}, 32'(bus.err_L), 32'(err_e));
  endtask

  initial begin
    int         nk, pendr;
    bit         seen;
    int         hold, late_i, late_n, lim, v;
    rst_n         = 1'b0;
    bus.Inicio_L  = 1'b0;
    bus.Fin_ciclo = 1'b0;
    bus.dato_in   = 8'h00;
    #12;
    chk_reset_vals("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("idle_after_reset");

    for (int k = 0; k < 9; k++) dat[k] = nominal[k];
    run_seq("nominal", -1, -1, 0, 1'b0);

    dat[2] = 8'h24;
    dat[4] = 8'h1A;
    run_seq("range_err", -1, -1, 0, 1'b0);

    for (int k = 0; k < 9; k++) dat[k] = nominal[k];
    run_seq("timeout", 4, -1, 0, 1'b0);

    run_seq("fin_on_timeout", -1, 3, TO, 1'b0);

    run_seq("ignored_inputs", -1, -1, 0, 1'b1);

    // Reset while waiting on the timer-seconds register.
    nk    = 0;
    pendr = -1;
    seen  = 1'b0;
    @(negedge clk);
    bus.Inicio_L = 1'b1;
    for (int c = 1; c < 60 && !seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.Inicio_L  = 1'b0;
      bus.Fin_ciclo = 1'b0;
      if (c == pendr) begin
        bus.Fin_ciclo = 1'b1;
        bus.dato_in   = dat[nk % 9];
        nk++;
      end
      if (bus.Rd_req) begin
        if (bus.dir_R == 8'h41) seen = 1'b1;
        else pendr = c + 1;
      end
    end
    chk("rst_mid reached_idx6", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid in_wait", 32'(bus.ocupado), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid async");
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid quiet", {29'd0, bus.Fin_L, bus.Wr_local, bus.Rd_req}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid released");
    run_seq("after_reset", -1, -1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 9; k++) begin
        lim = lim_dec[k];
        if ($urandom_range(3, 0) == 0) begin
          dat[k] = 8'($urandom);
        end else begin
          v      = int'($urandom_range(lim, 0));
          dat[k] = {4'(v / 10), 4'(v % 10)};
        end
      end
      hold   = (r % 3 == 2) ? int'($urandom_range(8, 0)) : -1;
      late_i = int'($urandom_range(8, 0));
      late_n = int'($urandom_range(TO, 0));
      run_seq($sformatf("random%0d", r), hold, late_i, late_n, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
